// File: rtl/count_pwm.sv
// PWM generator driven by an external free-running counter, with a double-buffered duty register.
// Optional build macro COUNT_PWM_FULL_ON_EN: maximum duty holds pwm_o high for the whole period.
module count_pwm #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             R,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             en,
    input  logic [WIDTH-1:0] duty_i,
    input  logic             duty_we,
    output logic             pwm_o,
    output logic             wrap_o,
    output logic             seq_err_o,
    output logic [WIDTH-1:0] duty_q
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SYNC = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [WIDTH-1:0] prev_cnt;
    logic [WIDTH-1:0] duty_sh;
    logic [WIDTH-1:0] duty_nx;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt_inc;
    logic             pwm_nx;
    logic             wrap_nx;
    logic             err_nx;
    logic             cnt_zero;
    logic             is_hold;
    logic             is_step;
    logic             period_start;

    function automatic logic pwm_cmp(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
`ifdef COUNT_PWM_FULL_ON_EN
        return (d == CNT_MAX) || (c < d);
`else
        return c < d;
`endif
    endfunction

    // A write in the same cycle as a period start bypasses the shadow register.
    assign load_val     = duty_we ? duty_i : duty_sh;
    assign cnt_inc      = prev_cnt + WIDTH'(1);
    assign cnt_zero     = (cnt_i == '0);
    assign is_hold      = (cnt_i == prev_cnt);
    assign is_step      = (cnt_i == cnt_inc);
    assign period_start = cnt_zero && !is_hold;

    always_comb begin
        state_nx = state;
        duty_nx  = duty_q;
        pwm_nx   = 1'b0;
        wrap_nx  = 1'b0;
        err_nx   = seq_err_o;
        case (state)
            IDLE: begin
                err_nx = 1'b0;
                if (en) state_nx = SYNC;
            end
            SYNC: begin
                if (!en) begin
                    state_nx = IDLE;
                    err_nx   = 1'b0;
                end else if (cnt_zero) begin
                    state_nx = RUN;
                    duty_nx  = load_val;
                    pwm_nx   = pwm_cmp('0, load_val);
                end
            end
            RUN: begin
                if (!en) begin
                    state_nx = IDLE;
                    err_nx   = 1'b0;
                end else begin
                    // Wrap and upstream restart both open a new period; only a true wrap is reported.
                    if (period_start) begin
                        duty_nx = load_val;
                        wrap_nx = (prev_cnt == CNT_MAX);
                    end else if (!is_hold && !is_step) begin
                        err_nx = 1'b1;
                    end
                    pwm_nx = pwm_cmp(cnt_i, duty_nx);
                end
            end
            default: begin
                state_nx = IDLE;
                err_nx   = 1'b0;
            end
        endcase
    end

    // Output/state register stage
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state     <= IDLE;
            prev_cnt  <= '0;
            duty_sh   <= '0;
            duty_q    <= '0;
            pwm_o     <= 1'b0;
            wrap_o    <= 1'b0;
            seq_err_o <= 1'b0;
        end else begin
            state     <= state_nx;
            prev_cnt  <= cnt_i;
            if (duty_we) duty_sh <= duty_i;
            duty_q    <= duty_nx;
            pwm_o     <= pwm_nx;
            wrap_o    <= wrap_nx;
            seq_err_o <= err_nx;
        end
    end

endmodule

// File: tb/tb_count_pwm.sv
// Scoreboard bench for count_pwm: a cycle model queues expected outputs, which are compared one clock later.
module tb_count_pwm;

    logic       clk;
    logic       R;
    logic [3:0] cnt_i;
    logic       en;
    logic [3:0] duty_i;
    logic       duty_we;
    logic       pwm_o;
    logic       wrap_o;
    logic       seq_err_o;
    logic [3:0] duty_q;

    count_pwm #(.WIDTH(4)) dut (
        .clk(clk), .R(R), .cnt_i(cnt_i), .en(en), .duty_i(duty_i), .duty_we(duty_we),
        .pwm_o(pwm_o), .wrap_o(wrap_o), .seq_err_o(seq_err_o), .duty_q(duty_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int hi_cnt = 0;
    int wr_cnt = 0;
    logic [3:0] ctr;
    logic [6:0] exp_q[$];

    // reference model state (0 idle, 1 sync, 2 run)
    int         m_state;
    logic [3:0] m_prev, m_sh, m_dq;
    logic       m_pwm, m_wrap, m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic ref_cmp(input logic [3:0] c, input logic [3:0] d);
`ifdef COUNT_PWM_FULL_ON_EN
        if (d == 4'hf) return 1'b1;
`endif
        return c < d;
    endfunction

    task automatic model(input logic [3:0] c, input logic e, input logic we, input logic [3:0] d);
        logic [3:0] ld;
        logic [3:0] delta;
        if (!R) begin
            m_state = 0; m_prev = 0; m_sh = 0; m_dq = 0;
            m_pwm = 0; m_wrap = 0; m_err = 0;
            return;
        end
        ld     = we ? d : m_sh;
        delta  = c - m_prev;
        m_pwm  = 1'b0;
        m_wrap = 1'b0;
        case (m_state)
            0: begin
                m_err = 1'b0;
                if (e) m_state = 1;
            end
            1: begin
                if (!e) begin
                    m_state = 0; m_err = 1'b0;
                end else if (c == 4'd0) begin
                    m_state = 2; m_dq = ld; m_pwm = ref_cmp(4'd0, ld);
                end
            end
            default: begin
                if (!e) begin
                    m_state = 0; m_err = 1'b0;
                end else begin
                    if (c == 4'd0 && delta != 4'd0) begin
                        m_dq   = ld;
                        m_wrap = (m_prev == 4'hf);
                    end else if (delta > 4'd1) begin
                        m_err = 1'b1;
                    end
                    m_pwm = ref_cmp(c, m_dq);
                end
            end
        endcase
        if (we) m_sh = d;
        m_prev = c;
    endtask

    task automatic step(input logic [3:0] c, input logic e, input logic we, input logic [3:0] d);
        logic [6:0] exp;
        cnt_i = c; en = e; duty_we = we; duty_i = d;
        model(c, e, we, d);
        exp_q.push_back({m_pwm, m_wrap, m_err, m_dq});
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        chk("sb", {25'd0, pwm_o, wrap_o, seq_err_o, duty_q}, {25'd0, exp});
        hi_cnt += int'(pwm_o);
        wr_cnt += int'(wrap_o);
    endtask

    task automatic tick(input logic we, input logic [3:0] d);
        step(ctr, 1'b1, we, d);
        ctr = ctr + 4'd1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'd0);
    endtask

    initial begin
        R = 1'b0; en = 1'b0; cnt_i = 4'd0; duty_i = 4'd0; duty_we = 1'b0; ctr = 4'd0;
        m_state = 0; m_prev = 0; m_sh = 0; m_dq = 0; m_pwm = 0; m_wrap = 0; m_err = 0;

        // reset held with en=1 and counter running
        ticks(6);
        chk("rst_pwm", {31'd0, pwm_o}, 32'd0);
        chk("rst_wrap", {31'd0, wrap_o}, 32'd0);
        chk("rst_err", {31'd0, seq_err_o}, 32'd0);
        chk("rst_duty", {28'd0, duty_q}, 32'd0);
        R = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(ctr, 1'b0, 1'b0, 4'd0);
            ctr = ctr + 4'd1;
        end
        chk("idle_out", {25'd0, pwm_o, wrap_o, seq_err_o, duty_q}, 32'd0);
        step(ctr, 1'b0, 1'b1, 4'd5);
        ctr = ctr + 4'd1;

        // sync then duty 5
        for (int i = 0; i < 16 && ctr != 4'd0; i++) tick(1'b0, 4'd0);
        hi_cnt = 0; wr_cnt = 0;
        ticks(16);
        chk("p1_high", hi_cnt, 32'd5);
        chk("p1_wrap", wr_cnt, 32'd0);
        hi_cnt = 0; wr_cnt = 0;
        ticks(16);
        chk("p2_high", hi_cnt, 32'd5);
        chk("p2_wrap", wr_cnt, 32'd1);

        // mid-period update to 12
        hi_cnt = 0;
        ticks(3);
        tick(1'b1, 4'd12);
        ticks(12);
        chk("mid_high_old", hi_cnt, 32'd5);
        chk("mid_dq_old", {28'd0, duty_q}, 32'd5);
        hi_cnt = 0;
        tick(1'b0, 4'd0);
        chk("mid_dq_new", {28'd0, duty_q}, 32'd12);
        ticks(15);
        chk("mid_high_new", hi_cnt, 32'd12);

        // duty 0
        ticks(5);
        tick(1'b1, 4'd0);
        ticks(10);
        hi_cnt = 0;
        ticks(16);
        chk("d0_high", hi_cnt, 32'd0);

        // duty 15
        ticks(4);
        tick(1'b1, 4'd15);
        ticks(11);
        hi_cnt = 0;
        ticks(16);
`ifdef COUNT_PWM_FULL_ON_EN
        chk("d15_high", hi_cnt, 32'd16);
`else
        chk("d15_high", hi_cnt, 32'd15);
`endif

        // write on the wrap edge
        hi_cnt = 0;
        tick(1'b1, 4'd9);
        chk("wrap_byp_dq", {28'd0, duty_q}, 32'd9);
        ticks(15);
        chk("wrap_byp_high", hi_cnt, 32'd9);

        // upstream counter restart at 7
        ticks(8);
        ctr = 4'd0;
        hi_cnt = 0; wr_cnt = 0;
        tick(1'b0, 4'd0);
        chk("rst_nowrap", {31'd0, wrap_o}, 32'd0);
        ticks(15);
        chk("restart_high", hi_cnt, 32'd9);
        chk("restart_wrap", wr_cnt, 32'd0);
        step(4'd15, 1'b1, 1'b0, 4'd0);
        chk("hold_err", {31'd0, seq_err_o}, 32'd0);

        // illegal jump 4 -> 9
        ticks(5);
        ctr = 4'd9;
        tick(1'b0, 4'd0);
        chk("seq_err_set", {31'd0, seq_err_o}, 32'd1);
        ticks(3);
        chk("seq_err_sticky", {31'd0, seq_err_o}, 32'd1);
        step(ctr, 1'b0, 1'b0, 4'd0);
        ctr = ctr + 4'd1;
        chk("seq_err_clr", {31'd0, seq_err_o}, 32'd0);

        // asynchronous reset while pwm_o is high
        for (int i = 0; i < 16 && ctr != 4'd0; i++) tick(1'b0, 4'd0);
        ticks(3);
        chk("pre_arst_pwm", {31'd0, pwm_o}, 32'd1);
        #2 R = 1'b0;
        #1;
        chk("arst_pwm", {31'd0, pwm_o}, 32'd0);
        chk("arst_duty", {28'd0, duty_q}, 32'd0);
        ticks(2);
        R = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(ctr, 1'b0, 1'b0, 4'd0);
            ctr = ctr + 4'd1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
